inv_stock_mmio: RTL
===================

# inv_stock_mmio

Memory-mapped inventory stock peripheral on the RISC-V core's data bus, directly downstream of `top_riscv`'s load/store path. It holds 16 item counters and applies add/remove commands as single-cycle read-modify-writes. Items falling below a programmable threshold are reported through a low-stock event queue and an interrupt line. Firmware on the core drives all inventory bookkeeping through this block.

## Interface
- `N_ITEMS`, 16: number of item counters (power of two, ≤16).
- `EVT_DEPTH`, 4: low-stock event FIFO depth (power of two).
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low. The block is held in reset while `reset`=0 at a rising edge.
- `req_valid` in 1: bus request valid.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 for write, 0 for read.
- `req_addr` in 8: byte address, word-aligned (bits[1:0] are ignored).
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: response strobe, one cycle wide.
- `rsp_rdata` out 32: read data. Zero for write responses.
- `irq` out 1: low-stock interrupt, level-sensitive.

## Operation
- **Register map**
  - 0x00–0x3C `COUNT[i]`: R/W. bits[15:0] hold the count; a write sets the count directly and does not generate events.
  - 0x40 `CMD`: W. bits[3:0] = item, bit4 = op (0 add, 1 remove), bits[31:16] = qty. Reads return 0.
  - 0x44 `THRESH`: R/W. bits[15:0] hold the threshold.
  - 0x48 `STATUS`: R. bit0 = evt_empty, bit1 = evt_full, bit2 = err_underflow, bit3 = err_saturate, bit4 = evt_overflow, bits[10:8] = FIFO level. Bits 2–4 are sticky and are cleared by a STATUS read.
  - 0x4C `EVENT`: R. With the FIFO enabled, a read pops one entry: bit31 = entry valid, bits[3:0] = item. Reading an empty FIFO returns 0 and does not pop.
  - Unmapped addresses read 0; writes to them are ignored but still acknowledged.
- **Handshake:** a request is accepted when `req_valid` && `req_ready`. The requester holds its signals until acceptance.
- **FSM states:** IDLE, UPDATE.
  - IDLE → UPDATE on an accepted CMD write. `req_ready`=0 during UPDATE.
  - UPDATE → IDLE always, after one cycle.
  - All other accesses complete in IDLE without leaving it.
- **CMD arithmetic:** 17-bit intermediate result.
  - Add: a result above 0xFFFF clamps to 0xFFFF and sets err_saturate.
  - Remove with qty > count: the count is unchanged and err_underflow is set.
  - qty = 0: no change and no event.
- **Low-stock event:** generated when an applied CMD moves a count from ≥THRESH to <THRESH. At most one event per CMD. It is pushed into the FIFO in the UPDATE cycle.
- **FIFO full on push:** the new event is dropped and evt_overflow is set.
- **Push and pop in the same cycle:** both take effect and the level is unchanged. When the FIFO is empty, the push is not bypassed to the reader.
- **`irq`:** equals !evt_empty.
- **Reset values:** all counts 0, THRESH 0, FIFO empty, sticky flags 0, FSM in IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `irq`=0. A reset asserted during UPDATE abandons the command; no partial write is applied.

## Timing
- Read accepted at edge T → `rsp_valid`=1 and `rsp_rdata` valid in cycle T+1.
- Non-CMD write accepted at T → register updated at T. `rsp_valid` in T+1.
- CMD accepted at T → counter written and event pushed at edge T+1. `rsp_valid` in T+2. `req_ready` is low for cycle T+1.
- `irq` rises in the cycle after the push edge. It falls the cycle after the pop that empties the FIFO.
- Back-to-back reads and writes sustain one request per cycle. A CMD sustains one per two cycles.

## Configuration
- `INV_EVENT_FIFO_EN` defined: the FIFO, evt_full, evt_overflow and level fields are built as described above.
- `INV_EVENT_FIFO_EN` undefined: no FIFO is built.
  - An EVENT read returns the live bitmap in bits[15:0]: bit i = (COUNT[i] < THRESH). The read has no side effects.
  - `irq` = OR of that bitmap.
  - STATUS bits 0, 1, 4 and 10:8 read 0.

## Test plan
- Reset with `reset`=0 for 20 cycles, then release → all COUNT, THRESH and STATUS read 0, `irq`=0, `req_ready`=1.
- Write THRESH=10, write COUNT[3]=12, then CMD remove 5 on item 3 → COUNT[3]=7, `irq`=1, EVENT read = 0x80000003, `irq`=0 afterwards.
- COUNT[5]=4, CMD remove 9 → COUNT[5] stays 4, STATUS bit2=1; a second STATUS read shows bit2=0.
- COUNT[0]=0xFFF0, CMD add 0x20 → COUNT[0]=0xFFFF, STATUS bit3=1.
- THRESH=100, five crossing CMDs on items 0–4 with no pops → level=4, evt_overflow=1, pops return items 0,1,2,3 then 0.
- Hold `reset`=0 on the cycle after a CMD is accepted → the count is unchanged at reset values and no response is issued.

Source files
------------

// File: rtl/inv_stock_mmio.sv
// Memory-mapped inventory stock peripheral: 16 item counters with add/remove commands and a low-stock event queue.
// Define INV_EVENT_FIFO_EN to build the event FIFO; otherwise EVENT reads return a live low-stock bitmap.
module inv_stock_mmio #(
  parameter int N_ITEMS   = 16,
  parameter int EVT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        irq
);
  // state  | meaning
  // IDLE   | accepting requests; reads and plain writes complete here
  // UPDATE | applying a latched CMD to its counter; req_ready low
  typedef enum logic {IDLE, UPDATE} state_t;

  localparam int          IW       = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam logic [5:0]  N_WORDS  = 6'(N_ITEMS);
  localparam logic [5:0]  A_CMD    = 6'h10;
  localparam logic [5:0]  A_THRESH = 6'h11;
  localparam logic [5:0]  A_STATUS = 6'h12;
  localparam logic [5:0]  A_EVENT  = 6'h13;

  state_t      state;
  logic [15:0] count [N_ITEMS];
  logic [15:0] thresh;
  logic        err_underflow;
  logic        err_saturate;
  logic [3:0]  cmd_item;
  logic        cmd_op;
  logic [15:0] cmd_qty;

  logic [5:0]  word;
  logic        accept;
  logic        is_count, is_cmd, is_thresh, is_status, is_event;
  logic        status_rd, event_rd;

  assign word      = req_addr[7:2];
  assign accept    = req_valid && req_ready && (state == IDLE);
  assign is_count  = word < N_WORDS;
  assign is_cmd    = word == A_CMD;
  assign is_thresh = word == A_THRESH;
  assign is_status = word == A_STATUS;
  assign is_event  = word == A_EVENT;
  assign status_rd = accept && !req_we && is_status;
  assign event_rd  = accept && !req_we && is_event;

  logic [15:0] cur;
  logic [16:0] sum;
  logic        underflow, saturate;
  logic [15:0] new_cnt;
  logic        low_evt;

  assign cur       = count[cmd_item[IW-1:0]];
  assign sum       = {1'b0, cur} + {1'b0, cmd_qty};
  assign underflow = cmd_op && (cmd_qty > cur);
  assign saturate  = !cmd_op && sum[16];

  always_comb begin
    new_cnt = cur;
    if (!cmd_op)
      new_cnt = sum[16] ? 16'hFFFF : sum[15:0];
    else if (!underflow)
      new_cnt = cur - cmd_qty;
  end

  // Add never lowers a count and an underflow leaves it unchanged, so only a real remove can cross.
  assign low_evt = (state == UPDATE) && (cmd_qty != 16'h0) && (cur >= thresh) && (new_cnt < thresh);

  logic        evt_empty, evt_full, evt_overflow;
  logic [2:0]  level_field;
  logic [31:0] event_rdata;
  logic        unused_bits;

`ifdef INV_EVENT_FIFO_EN
  localparam int           AW      = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam logic [AW:0]  DEPTH_L = (AW+1)'(EVT_DEPTH);

  logic [3:0]    evt_mem [EVT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          push_ok, pop;

  assign evt_empty = level == '0;
  assign evt_full  = level == DEPTH_L;
  assign push_ok   = low_evt && !evt_full;
  assign pop       = event_rd && !evt_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (status_rd) evt_overflow <= 1'b0;
      if (low_evt) begin
        if (evt_full) begin
          evt_overflow <= 1'b1;
        end else begin
          evt_mem[wr_ptr] <= cmd_item;
          wr_ptr          <= wr_ptr + 1'b1;
        end
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign event_rdata = evt_empty ? 32'h0 : {1'b1, 27'h0, evt_mem[rd_ptr]};
  assign level_field = 3'(level);
  assign irq         = !evt_empty;
  assign unused_bits = ^{req_addr[1:0], cmd_item};
`else
  logic [15:0] low_map;

  always_comb begin
    low_map = '0;
    for (int i = 0; i < N_ITEMS; i++)
      low_map[i] = count[i] < thresh;
  end

  assign evt_empty    = 1'b0;
  assign evt_full     = 1'b0;
  assign evt_overflow = 1'b0;
  assign level_field  = 3'h0;
  assign event_rdata  = {16'h0, low_map};
  assign irq          = |low_map;
  assign unused_bits  = ^{req_addr[1:0], cmd_item, low_evt, (EVT_DEPTH > 0)};
`endif

  logic [31:0] rd_data;

  always_comb begin
    rd_data = 32'h0;
    if (is_count)
      rd_data = {16'h0, count[word[IW-1:0]]};
    else if (is_thresh)
      rd_data = {16'h0, thresh};
    else if (is_status)
      rd_data = {21'h0, level_field, 3'h0, evt_overflow, err_saturate, err_underflow,
                 evt_full, evt_empty};
    else if (is_event)
      rd_data = event_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'h0;
      thresh        <= 16'h0;
      err_underflow <= 1'b0;
      err_saturate  <= 1'b0;
      cmd_item      <= 4'h0;
      cmd_op        <= 1'b0;
      cmd_qty       <= 16'h0;
      for (int i = 0; i < N_ITEMS; i++) count[i] <= 16'h0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_we) begin
              if (is_count)
                count[word[IW-1:0]] <= req_wdata[15:0];
              else if (is_thresh)
                thresh <= req_wdata[15:0];
              if (is_cmd) begin
                cmd_item  <= req_wdata[3:0];
                cmd_op    <= req_wdata[4];
                cmd_qty   <= req_wdata[31:16];
                state     <= UPDATE;
                req_ready <= 1'b0;
              end else begin
                rsp_valid <= 1'b1;
              end
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_data;
              if (is_status) begin
                err_underflow <= 1'b0;
                err_saturate  <= 1'b0;
              end
            end
          end
        end
        UPDATE: begin
          count[cmd_item[IW-1:0]] <= new_cnt;
          if (underflow) err_underflow <= 1'b1;
          if (saturate)  err_saturate  <= 1'b1;
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
